display_source_scheduler: RTL and testbench

DISPLAY_SOURCE_SCHEDULER -- requirements
Module: display_source_scheduler

---
 rtl/display_sched_pkg.sv | 20 ++
 rtl/switch_debouncer.sv | 52 +++++
 rtl/display_source_scheduler.sv | 123 ++++++++++++
 tb/tb_display_source_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display source scheduler.
// Holds the FSM state encoding, source select codes and a counter-width helper.
package display_sched_pkg;

  typedef enum logic [1:0] {
    SHOW_F     = 2'd0,
    BLANK_TO_C = 2'd1,
    SHOW_C     = 2'd2,
    BLANK_TO_F = 2'd3
  } sched_state_t;

  localparam logic SRC_FREQ = 1'b0;
  localparam logic SRC_CURR = 1'b1;

  // Counter width for a terminal count of n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus level debouncer for the raw source switch.
// toggled pulses for one cycle, on the first cycle the new level is visible.
module switch_debouncer
  import display_sched_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic switch,
  output logic level,
  output logic toggled
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
    end
  end

  // cnt counts consecutive disagreeing cycles; one agreeing cycle restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      level   <= 1'b0;
      toggled <= 1'b0;
    end else begin
      toggled <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        level   <= sync2;
        toggled <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// Chooses which indicator (frequency or current) drives the display, either by
// the debounced switch or by timed auto-rotation, with a blanking gap on each change.
module display_source_scheduler
  import display_sched_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DWELL_CYCLES    = 100000000,
  parameter int unsigned BLANK_CYCLES    = 2500000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         switch,
  input  logic         auto_en,
  input  logic [2:0]   iF,
  input  logic [3:0]   iC,
  output logic         sel,
  output logic         blank,
  output logic [2:0]   iF_q,
  output logic [3:0]   iC_q,
  output logic         src_chg,
  output sched_state_t fsm_state
);

  localparam int unsigned DW = cnt_width(DWELL_CYCLES);
  localparam int unsigned BW = cnt_width(BLANK_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  sched_state_t  state;
  sched_state_t  next_state;
  logic          db_level;
  logic          db_toggled;
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] blank_cnt;
  logic          in_show;
  logic          in_blank;
  logic          dwell_expired;
  logic          blank_done;
  logic          want_switch;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock  (clock),
    .reset  (reset),
    .switch (switch),
    .level  (db_level),
    .toggled(db_toggled)
  );

  assign in_show       = (state == SHOW_F) || (state == SHOW_C);
  assign in_blank      = (state == BLANK_TO_C) || (state == BLANK_TO_F);
  assign dwell_expired = (dwell_cnt == DWELL_LAST);
  assign blank_done    = (blank_cnt == BLANK_LAST);

  // sel follows the shown source, so it keeps the old value through the blank.
  assign sel       = (state == SHOW_C) || (state == BLANK_TO_F);
  assign blank     = in_blank;
  assign fsm_state = state;

  // Auto mode merges expiry and edge into one request, so a coincidence toggles once.
  assign want_switch = auto_en ? (dwell_expired || db_toggled) : (db_level != sel);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SHOW_F;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      SHOW_F:     if (want_switch) next_state = BLANK_TO_C;
      SHOW_C:     if (want_switch) next_state = BLANK_TO_F;
      BLANK_TO_C: if (blank_done) next_state = SHOW_C;
      BLANK_TO_F: if (blank_done) next_state = SHOW_F;
      default:    next_state = SHOW_F;
    endcase
  end

  // Dwell only runs while showing in auto mode; any state change restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
    end else if (!in_show || !auto_en || (next_state != state)) begin
      dwell_cnt <= '0;
    end else if (!dwell_expired) begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blank_cnt <= '0;
    end else if (in_blank && !blank_done) begin
      blank_cnt <= blank_cnt + 1'b1;
    end else begin
      blank_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_chg <= 1'b0;
    end else begin
      src_chg <= in_blank && blank_done;
    end
  end

  // Loading on next_state means the first cycle of a new source already shows live data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iF_q <= '0;
      iC_q <= '0;
    end else if ((next_state == SHOW_F) || (next_state == SHOW_C)) begin
      iF_q <= iF;
      iC_q <= iC;
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Self-checking bench for display_source_scheduler with short timing parameters.
// A cycle-level reference model built from the scheduling rules is compared every cycle.
module tb_display_source_scheduler;
  import display_sched_pkg::*;

  localparam int DEB   = 4;
  localparam int DWELL = 20;
  localparam int BLANK = 3;

  // clock / reset
  logic         clock   = 1'b0;
  logic         reset   = 1'b0;
  logic         switch  = 1'b0;
  logic         auto_en = 1'b0;
  logic [2:0]   iF      = '0;
  logic [3:0]   iC      = '0;
  logic         sel;
  logic         blank;
  logic [2:0]   iF_q;
  logic [3:0]   iC_q;
  logic         src_chg;
  sched_state_t fsm_state;

  always #5 clock = ~clock;

  display_source_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_CYCLES   (DWELL),
    .BLANK_CYCLES   (BLANK)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .switch   (switch),
    .auto_en  (auto_en),
    .iF       (iF),
    .iC       (iC),
    .sel      (sel),
    .blank    (blank),
    .iF_q     (iF_q),
    .iC_q     (iC_q),
    .src_chg  (src_chg),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];

  // reference model: shown source, blank time left, dwell elapsed, debounce run
  logic       sw_q[$];
  logic       m_level, m_edge, m_shown, m_target, m_chg;
  int         m_run, m_blank_left, m_dwell;
  logic [2:0] m_fq;
  logic [3:0] m_cq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic sched_state_t exp_state();
    if (m_blank_left > 0) return m_target ? BLANK_TO_C : BLANK_TO_F;
    return m_shown ? SHOW_C : SHOW_F;
  endfunction

  task automatic model_reset();
    sw_q = {1'b0, 1'b0};
    m_level = 0; m_edge = 0; m_shown = SRC_FREQ; m_target = 0; m_chg = 0;
    m_run = 0; m_blank_left = 0; m_dwell = 0; m_fq = '0; m_cq = '0;
  endtask

  task automatic model_step();
    logic synced, lvl_now, edge_now;
    synced = sw_q.pop_front();
    sw_q.push_back(switch);
    lvl_now  = m_level;
    edge_now = m_edge;
    m_edge   = 0;
    if (synced != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = synced; m_run = 0; m_edge = 1;
      end
    end else begin
      m_run = 0;
    end
    m_chg = 0;
    if (m_blank_left > 0) begin
      m_blank_left--;
      if (m_blank_left == 0) begin
        m_shown = m_target; m_chg = 1; m_dwell = 0;
      end
    end else if (auto_en ? (m_dwell == DWELL - 1 || edge_now) : (lvl_now != m_shown)) begin
      m_blank_left = BLANK; m_target = !m_shown; m_dwell = 0;
    end else begin
      m_dwell = auto_en ? m_dwell + 1 : 0;
    end
    if (m_blank_left == 0) begin
      m_fq = iF; m_cq = iC;
    end
  endtask

  task automatic compare_all();
    check("sel", sel, m_shown);
    check("blank", blank, m_blank_left > 0);
    check("src_chg", src_chg, m_chg);
    check("iF_q", iF_q, m_fq);
    check("iC_q", iC_q, m_cq);
    check("state", 32'(fsm_state), 32'(exp_state()));
  endtask

  // driver tasks
  task automatic step(input logic sw, input logic ae, input logic [2:0] f, input logic [3:0] c);
    switch = sw; auto_en = ae; iF = f; iC = c;
    @(posedge clock);
    cyc++;
    if (reset) model_step();
    #1;
    compare_all();
  endtask

  task automatic hold_reset(input int n, input logic sw, input logic [2:0] f);
    reset = 1'b0; switch = sw; iF = f;
    #1;
    model_reset();
    compare_all();
    repeat (n) begin
      @(posedge clock);
      #1;
      compare_all();
    end
    reset = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rise, moved, nblank, found, run_left;
    logic sw, ae;
    @(posedge clock);
    #1;

    // power-up reset with switch high, then manual select of current
    hold_reset(5, 1'b1, 3'd5);
    first_rise = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b0, 3'd5, 4'd0);
      if (sel && first_rise == 0) first_rise = cyc;
    end
    check("sel_rise_cycle", first_rise, 10);

    // bouncing switch must never get through the debouncer
    hold_reset(2, 1'b0, 3'd0);
    moved = 0;
    for (int k = 0; k < 20; k++) begin
      step(((k / 2) % 2) == 0, 1'b0, 3'(k), 4'(k));
      if (sel || blank) moved++;
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 3'd1, 4'd2);
      if (sel || blank) moved++;
    end
    check("bounce_moves", moved, 0);

    // auto rotation timing through the expected-change queue
    hold_reset(2, 1'b0, 3'd0);
    exp_q = {32'd23, 32'd46, 32'd69, 32'd92};
    nblank = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      if (blank) nblank++;
      if (src_chg) begin
        if (exp_q.size() > 0) check("chg_cycle", cyc, exp_q.pop_front());
        else check("chg_extra", cyc, 0);
      end
    end
    check("blank_cycles", nblank, 12);
    check("chg_missing", exp_q.size(), 0);

    // held indicator across BLANK_TO_C
    hold_reset(2, 1'b0, 3'd0);
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b1, 3'd2, (k >= 21) ? 4'd3 : 4'd9);
      if (k == 21 || k == 22) check("iC_q_hold", iC_q, 9);
      if (k == 23) check("iC_q_first_show", iC_q, 3);
    end

    // debounced edge coincident with dwell expiry, then an edge inside a blank
    hold_reset(2, 1'b0, 3'd0);
    for (int k = 1; k <= 70; k++) begin
      step((k >= 14 && k < 39), 1'b1, 3'd0, 4'd0);
      if (k == 22 || k == 46 || k == 68) check("coinc_sel_lo", sel, 0);
      if (k == 23 || k == 45 || k == 69) check("coinc_sel_hi", sel, 1);
    end

    // reset in the middle of BLANK_TO_C
    hold_reset(2, 1'b0, 3'd0);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      step(1'b0, 1'b1, 3'd4, 4'd4);
      if (fsm_state == BLANK_TO_C) found = 1;
    end
    check("reached_blank", found, 1);
    hold_reset(2, 1'b0, 3'd0);
    check("mid_reset_state", 32'(fsm_state), 32'(SHOW_F));

    // randomized mix of switch activity, mode changes and resets
    sw = 0; ae = 0; run_left = 0;
    for (int k = 0; k < 700; k++) begin
      if (run_left == 0) begin
        sw = $urandom_range(0, 1);
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      if ($urandom_range(0, 49) == 0) ae = !ae;
      if ($urandom_range(0, 299) == 0) hold_reset($urandom_range(1, 3), sw, 3'd0);
      step(sw, ae, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
